// File: rtl/program_loader.sv
// program_loader
// Boot-time loader that receives a framed 16-bit word stream and writes the
// program into instruction memory through the fetch-module write port. The
// processor is held in reset until the frame checksum verifies. The fetch
// memory reset is pulsed once at the start of every load.
//
// Frame: header N, then N data words, then checksum C (with in_last=1).
// C must equal the 16-bit wrapping sum of the data words.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   start           one-cycle load request (honoured in IDLE, DONE, ERR)
//   in_data/in_valid/in_ready/in_last   stream input, transfer = valid & ready
//   write_enable_fm/write_data_fm/write_addr_fm   instruction-memory write port
//   rst_fm          fetch-module reset pulse
//   cpu_hold        high = keep the processor in reset
//   busy            high while a load is in progress
//   done / error    outcome of the last load
//   word_count      data words written in the current or last load
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic        write_enable_fm,
  output logic [15:0] write_data_fm,
  output logic [31:0] write_addr_fm,
  output logic        rst_fm,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_HDR, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state, state_next;
  logic [15:0] length, length_next;
  logic [15:0] sum, sum_next;
  logic [15:0] word_count_next;
  logic [15:0] write_data_next;
  logic [31:0] write_addr_next;
  logic        write_enable_next;
  logic        in_ready_next, rst_fm_next, cpu_hold_next, busy_next;
  logic        done_next, error_next;
  logic        xfer;

  // in_ready is a register reflecting the current state, so a transfer is
  // simply valid & ready sampled at the clock edge.
  assign xfer = in_valid & in_ready;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      length          <= '0;
      sum             <= '0;
      word_count      <= '0;
      write_enable_fm <= 1'b0;
      write_data_fm   <= '0;
      write_addr_fm   <= '0;
      in_ready        <= 1'b0;
      rst_fm          <= 1'b0;
      cpu_hold        <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      state           <= state_next;
      length          <= length_next;
      sum             <= sum_next;
      word_count      <= word_count_next;
      write_enable_fm <= write_enable_next;
      write_data_fm   <= write_data_next;
      write_addr_fm   <= write_addr_next;
      in_ready        <= in_ready_next;
      rst_fm          <= rst_fm_next;
      cpu_hold        <= cpu_hold_next;
      busy            <= busy_next;
      done            <= done_next;
      error           <= error_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_CLR;
      S_CLR:  state_next = S_HDR;
      S_HDR: begin
        if (xfer) begin
          if (({1'b0, in_data} > MAX_LEN) || in_last) state_next = S_ERR;
          else if (in_data == 16'd0)                  state_next = S_CHK;
          else                                        state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (in_last)                               state_next = S_ERR;
          else if (word_count + 16'd1 == length)     state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (!in_last || in_data != sum) state_next = S_ERR;
          else                            state_next = S_DONE;
        end
      end
      S_DONE:  if (start) state_next = S_CLR;
      S_ERR:   if (start) state_next = S_CLR;
      default: state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values. Status outputs are decoded from the
  // upcoming state so that the registered versions line up with the state.
  always_comb begin
    length_next       = length;
    sum_next          = sum;
    word_count_next   = word_count;
    write_data_next   = write_data_fm;
    write_addr_next   = write_addr_fm;
    write_enable_next = 1'b0;
    case (state)
      S_CLR: begin
        sum_next        = '0;
        word_count_next = '0;
      end
      S_HDR: if (xfer) length_next = in_data;
      S_DATA: begin
        // A data word flagged as last is a framing error and is not written.
        if (xfer && !in_last) begin
          write_enable_next = 1'b1;
          write_data_next   = in_data;
          write_addr_next   = BASE_ADDR + {16'd0, word_count};
          word_count_next   = word_count + 16'd1;
          sum_next          = sum + in_data;
        end
      end
      default: ;
    endcase
    in_ready_next = (state_next == S_HDR) || (state_next == S_DATA) ||
                    (state_next == S_CHK);
    busy_next     = in_ready_next || (state_next == S_CLR);
    rst_fm_next   = (state_next == S_CLR);
    cpu_hold_next = (state_next != S_DONE);
    done_next     = (state_next == S_DONE);
    error_next    = (state_next == S_ERR);
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam logic [31:0] BASE = 32'hFFFF_FFFE;
  localparam int          MAXW = 1024;

  logic        clk, reset, start, in_valid, in_ready, in_last;
  logic        write_enable_fm, rst_fm, cpu_hold, busy, done, error;
  logic [15:0] in_data, write_data_fm, word_count;
  logic [31:0] write_addr_fm;

  int tests = 0;
  int fails = 0;

  logic [15:0] frame_w[$];
  bit          frame_l[$];
  logic [15:0] got_d[$];
  logic [31:0] got_a[$];
  int          rst_cnt;
  logic [15:0] exp_d[$];
  int          exp_k;
  bit          exp_done, exp_err;

  program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .write_enable_fm(write_enable_fm), .write_data_fm(write_data_fm),
    .write_addr_fm(write_addr_fm), .rst_fm(rst_fm), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record memory writes and fetch-reset cycles away from the active edge.
  always @(negedge clk) begin
    if (write_enable_fm) begin
      got_d.push_back(write_data_fm);
      got_a.push_back(write_addr_fm);
    end
    if (rst_fm) rst_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the frame by the framing rules to find how many words get
  // consumed, which data words are written, and the final outcome.
  task automatic model();
    int          n;
    logic [15:0] s;
    exp_d.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n        = int'(frame_w[0]);
    exp_k    = 1;
    if (n > MAXW || frame_l[0]) begin
      exp_err = 1'b1;
      return;
    end
    s = 16'd0;
    for (int i = 1; i <= n; i++) begin
      exp_k++;
      if (frame_l[i]) begin
        exp_err = 1'b1;
        return;
      end
      exp_d.push_back(frame_w[i]);
      s = s + frame_w[i];
    end
    exp_k++;
    if (frame_l[n+1] && frame_w[n+1] == s) exp_done = 1'b1;
    else                                   exp_err  = 1'b1;
  endtask

  // Offer the first k frame words, optionally with valid gaps and stray starts.
  task automatic drive(input int k, input bit gaps, input bit stray);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < k && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = frame_w[idx];
      in_last  = frame_l[idx];
      start    = stray && ($urandom_range(0, 3) == 0);
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    check("handshake_count", 32'(idx), 32'(k));
  endtask

  task automatic run_load(input bit gaps, input bit stray);
    int nw;
    model();
    got_d.delete();
    got_a.delete();
    rst_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    drive(exp_k, gaps, stray);
    repeat (2) @(negedge clk);
    check("rst_fm_pulses", 32'(rst_cnt), 32'd1);
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(exp_err));
    check("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
    check("busy_end", 32'(busy), 32'd0);
    check("in_ready_end", 32'(in_ready), 32'd0);
    check("word_count", 32'(word_count), 32'(exp_d.size()));
    check("write_count", 32'(got_d.size()), 32'(exp_d.size()));
    nw = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < nw; i++) begin
      check("write_data", 32'(got_d[i]), 32'(exp_d[i]));
      check("write_addr", got_a[i], BASE + 32'(i));
    end
    $display("[TB] load N=%0d consumed=%0d writes=%0d done=%0d error=%0d",
             frame_w[0], exp_k, got_d.size(), done, error);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_rst_fm"}, 32'(rst_fm), 32'd0);
    check({tag, "_we"}, 32'(write_enable_fm), 32'd0);
    check({tag, "_wdata"}, 32'(write_data_fm), 32'd0);
    check({tag, "_waddr"}, write_addr_fm, 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    int          n;
    logic [15:0] s;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 16'd0;
    #3 reset = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk); reset = 1'b1;

    // Good frame, continuous valid.
    frame_w = {16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h6666};
    frame_l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_load(1'b0, 1'b0);
    // Bad checksum.
    frame_w = {16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h6667};
    run_load(1'b0, 1'b0);
    // Premature last on a data word.
    frame_w = {16'd4, 16'hAAAA, 16'hBBBB};
    frame_l = {1'b0, 1'b0, 1'b1};
    run_load(1'b0, 1'b0);
    // Oversized header.
    frame_w = {16'd1025};
    frame_l = {1'b0};
    run_load(1'b0, 1'b0);
    // Empty program.
    frame_w = {16'd0, 16'h0000};
    frame_l = {1'b0, 1'b1};
    run_load(1'b0, 1'b0);
    // Wrapping sum with valid gaps and stray starts.
    frame_w = {16'd2, 16'hFFFF, 16'h0002, 16'h0001};
    frame_l = {1'b0, 1'b0, 1'b0, 1'b1};
    run_load(1'b1, 1'b1);

    // Reset in the middle of a load after one of three words.
    frame_w = {16'd3, 16'h1234, 16'h0001, 16'h0002, 16'h1237};
    frame_l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    drive(2, 1'b0, 1'b0);
    check("mid_we", 32'(write_enable_fm), 32'd1);
    check("mid_word_count", 32'(word_count), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk); reset = 1'b1;
    run_load(1'b0, 1'b0);

    // Randomized frames.
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) n = $urandom_range(1025, 65535);
      frame_w = {16'(n)};
      frame_l = {($urandom_range(0, 19) == 0)};
      s = 16'd0;
      if (n <= 6) begin
        for (int i = 0; i < n; i++) begin
          frame_w.push_back(16'($urandom));
          frame_l.push_back($urandom_range(0, 14) == 0);
          s = s + frame_w[i+1];
        end
        if ($urandom_range(0, 3) == 0) s = s ^ 16'(1 << $urandom_range(0, 15));
        frame_w.push_back(s);
        frame_l.push_back($urandom_range(0, 9) != 0);
      end
      run_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
